reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 73 +++++++
 tb/tb_reg_file_2r1w.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32-entry register file with two combinational read ports and one write port.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data to any read port that matches the write address.
module reg_file_2r1w #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(128),
  parameter int                 CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        RSaddr_i,
  input  logic [4:0]        RTaddr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [CNT_W-1:0]  wr_cnt_o,
  output logic [4:0]        last_wr_addr_o
);

  localparam int NUM_REGS = 32;
  localparam int SP_IDX   = 29;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  wr_cnt;
  logic [4:0]        last_wr_addr;
  logic              wr_commit;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  // Writes aimed at $zero are dropped entirely, so they neither store nor count.
  assign wr_commit = RegWrite_i && (RDaddr_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_commit) begin
      regs[RDaddr_i] <= RDdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_cnt       <= '0;
      last_wr_addr <= 5'd0;
    end else if (wr_commit) begin
      wr_cnt       <= wr_cnt + CNT_W'(1);
      last_wr_addr <= RDaddr_i;
    end
  end

  always_comb begin
    rs_stored = (RSaddr_i == 5'd0) ? '0 : regs[RSaddr_i];
    rt_stored = (RTaddr_i == 5'd0) ? '0 : regs[RTaddr_i];
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by reset so reads during reset always show reset values.
  logic byp_ok;
  assign byp_ok   = rst_i && wr_commit;
  assign RSdata_o = (byp_ok && (RDaddr_i == RSaddr_i)) ? RDdata_i : rs_stored;
  assign RTdata_o = (byp_ok && (RDaddr_i == RTaddr_i)) ? RDdata_i : rt_stored;
`else
  assign RSdata_o = rs_stored;
  assign RTdata_o = rt_stored;
`endif

  assign wr_cnt_o       = wr_cnt;
  assign last_wr_addr_o = last_wr_addr;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: randomized self-checking bench for reg_file_2r1w against an array-based reference model.
// Expectations for same-cycle read/write follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [4:0]        RSaddr_i;
  logic [4:0]        RTaddr_i;
  logic [4:0]        RDaddr_i;
  logic [DATA_W-1:0] RDdata_i;
  logic              RegWrite_i;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [CNT_W-1:0]  wr_cnt_o;
  logic [4:0]        last_wr_addr_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array of register contents plus an unbounded write tally.
  logic [31:0] m_regs [32];
  int          m_cnt;
  logic [4:0]  m_last;

  reg_file_2r1w #(.DATA_W(DATA_W), .SP_INIT(32'd128), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .RSaddr_i       (RSaddr_i),
    .RTaddr_i       (RTaddr_i),
    .RDaddr_i       (RDaddr_i),
    .RDdata_i       (RDdata_i),
    .RegWrite_i     (RegWrite_i),
    .RSdata_o       (RSdata_o),
    .RTdata_o       (RTdata_o),
    .wr_cnt_o       (wr_cnt_o),
    .last_wr_addr_o (last_wr_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd128 : 32'd0;
    m_cnt  = 0;
    m_last = 5'd0;
  endtask

  task automatic model_step();
    if (rst_i && RegWrite_i && RDaddr_i != 5'd0) begin
      m_regs[RDaddr_i] = RDdata_i;
      m_cnt++;
      m_last = RDaddr_i;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (rst_i && RegWrite_i && RDaddr_i == a) return RDdata_i;
`endif
    return m_regs[a];
  endfunction

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk_i);
    RegWrite_i = we;
    RDaddr_i   = rd;
    RDdata_i   = data;
    RSaddr_i   = rs;
    RTaddr_i   = rt;
  endtask

  task automatic clock_edge();
    @(posedge clk_i);
    model_step();
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      #1;
      checks++;
      if (RSdata_o !== exp_read(5'(a))) begin
        failures++;
        $display("[TB] FAIL reset_rs[%0d]: got %h expected %h", a, RSdata_o, exp_read(5'(a)));
      end
      checks++;
      if (RTdata_o !== exp_read(5'(31 - a))) begin
        failures++;
        $display("[TB] FAIL reset_rt[%0d]: got %h expected %h", 31 - a, RTdata_o, exp_read(5'(31 - a)));
      end
    end
    checks++;
    if (RSaddr_i == 5'd31 && RTdata_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_zero: got %h expected 0", RTdata_o);
    end
    drive(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd29);
    clock_edge();
    #1;
    checks++;
    if (RSdata_o !== 32'd0 || RTdata_o !== 32'd128) begin
      failures++;
      $display("[TB] FAIL reset_write_ignored: got %h/%h expected 0/80", RSdata_o, RTdata_o);
    end
    checks++;
    if (wr_cnt_o !== 4'd0 || last_wr_addr_o !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", wr_cnt_o, last_wr_addr_o);
    end
  endtask

  task automatic test_basic_write();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
    clock_edge();
    drive(1'b1, 5'd6, 32'h0000_0001, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 5'd9, 32'h1234_5678, 5'd5, 5'd6);
    #1;
    checks++;
    if (RSdata_o !== 32'hDEAD_BEEF || RTdata_o !== 32'h0000_0001) begin
      failures++;
      $display("[TB] FAIL basic_read: got %h/%h expected deadbeef/00000001", RSdata_o, RTdata_o);
    end
    checks++;
    if (wr_cnt_o !== CNT_W'(m_cnt) || last_wr_addr_o !== 5'd6) begin
      failures++;
      $display("[TB] FAIL basic_cnt: got %0d/%0d expected %0d/6", wr_cnt_o, last_wr_addr_o, CNT_W'(m_cnt));
    end
  endtask

  task automatic test_zero_protect();
    logic [CNT_W-1:0] cnt_before;
    logic [4:0]       last_before;
    cnt_before  = wr_cnt_o;
    last_before = last_wr_addr_o;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    checks++;
    if (RSdata_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL zero_pre_edge: got %h expected 0", RSdata_o);
    end
    clock_edge();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (RSdata_o !== 32'd0 || RTdata_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL zero_read: got %h/%h expected 0/0", RSdata_o, RTdata_o);
    end
    checks++;
    if (wr_cnt_o !== cnt_before || last_wr_addr_o !== last_before) begin
      failures++;
      $display("[TB] FAIL zero_cnt: got %0d/%0d expected %0d/%0d", wr_cnt_o, last_wr_addr_o, cnt_before, last_before);
    end
  endtask

  task automatic test_same_cycle_hazard();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    drive(1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    clock_edge();
    drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    #1;
    checks++;
    if (RSdata_o !== want || RTdata_o !== want) begin
      failures++;
      $display("[TB] FAIL hazard_pre_edge: got %h/%h expected %h", RSdata_o, RTdata_o, want);
    end
    clock_edge();
    drive(1'b0, 5'd7, 32'h33, 5'd7, 5'd7);
    #1;
    checks++;
    if (RSdata_o !== 32'h22 || RTdata_o !== 32'h22) begin
      failures++;
      $display("[TB] FAIL hazard_post_edge: got %h/%h expected 22", RSdata_o, RTdata_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd10, 32'h55, 5'd0, 5'd0);
    clock_edge();
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd29);
    #1;
    checks++;
    if (RSdata_o !== 32'h55) begin
      failures++;
      $display("[TB] FAIL async_pre: got %h expected 55", RSdata_o);
    end
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (RSdata_o !== 32'd0 || RTdata_o !== 32'd128) begin
      failures++;
      $display("[TB] FAIL async_now: got %h/%h expected 0/80", RSdata_o, RTdata_o);
    end
    checks++;
    if (wr_cnt_o !== 4'd0 || last_wr_addr_o !== 5'd0) begin
      failures++;
      $display("[TB] FAIL async_cnt: got %0d/%0d expected 0/0", wr_cnt_o, last_wr_addr_o);
    end
    drive(1'b1, 5'd10, 32'h77, 5'd10, 5'd29);
    #1;
    checks++;
    if (RSdata_o !== exp_read(5'd10)) begin
      failures++;
      $display("[TB] FAIL async_no_bypass: got %h expected %h", RSdata_o, exp_read(5'd10));
    end
    clock_edge();
    #1;
    checks++;
    if (RSdata_o !== 32'd0 || wr_cnt_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL async_write_ignored: got %h/%0d expected 0/0", RSdata_o, wr_cnt_o);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    rst_i = 1'b1;
  endtask

  task automatic test_counter_wrap();
    logic [4:0] rd;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    rst_i = 1'b0;
    model_reset();
    #2;
    rst_i = 1'b1;
    for (int n = 0; n < 17; n++) begin
      rd = 5'($urandom_range(1, 31));
      drive(1'b1, rd, $urandom, 5'd0, 5'd0);
      clock_edge();
      drive(1'b0, 5'($urandom_range(0, 31)), $urandom, 5'd0, 5'd0);
      clock_edge();
      #1;
      checks++;
      if (wr_cnt_o !== CNT_W'(m_cnt) || last_wr_addr_o !== m_last) begin
        failures++;
        $display("[TB] FAIL wrap_step[%0d]: got %0d/%0d expected %0d/%0d", n, wr_cnt_o, last_wr_addr_o, CNT_W'(m_cnt), m_last);
      end
    end
    checks++;
    if (wr_cnt_o !== 4'd1) begin
      failures++;
      $display("[TB] FAIL wrap_final: got %0d expected 1", wr_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), rd, $urandom, rs, rt);
      #1;
      checks++;
      if (RSdata_o !== exp_read(rs) || RTdata_o !== exp_read(rt)) begin
        failures++;
        $display("[TB] FAIL rand_read[%0d]: got %h/%h expected %h/%h", n, RSdata_o, RTdata_o, exp_read(rs), exp_read(rt));
      end
      clock_edge();
      #1;
      checks++;
      if (wr_cnt_o !== CNT_W'(m_cnt) || last_wr_addr_o !== m_last) begin
        failures++;
        $display("[TB] FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, wr_cnt_o, last_wr_addr_o, CNT_W'(m_cnt), m_last);
      end
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    RegWrite_i = 1'b0;
    RDaddr_i   = 5'd0;
    RDdata_i   = 32'd0;
    RSaddr_i   = 5'd0;
    RTaddr_i   = 5'd0;
    #2;
    rst_i = 1'b0;
    model_reset();
    test_reset();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    rst_i = 1'b1;
    test_basic_write();
    test_zero_protect();
    test_same_cycle_hazard();
    test_async_reset();
    test_random();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
